// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared FSM state encodings and derived-width helper for the
//               bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  // Controller states; fixed 2-bit encodings.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to hold WIDTH-1 with one bit of headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa.sv
`default_nettype none
// ============================================================================
// Module      : half_adder / full_adder
// Description : One-bit full adder built from two half adders and an OR.
//               Used as the per-bit datapath of the serial adder and intended
//               for reuse in a parallel ripple adder.
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.a(a),    .b(b),  .s(w_s0), .co(w_c0));
  half_adder u_ha1 (.a(w_s0), .b(ci), .s(s),    .co(w_c1));

  // Only one of the two half adders can generate a carry at a time.
  assign co = w_c0 | w_c1;
endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder with carry-in. One operand bit is
//               added per clock through a single registered full adder.
//               start/busy/done handshake, carry-out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W  = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_PREV = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cmsb;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  // Single full adder working on the LSBs of the shift registers.
  full_adder u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_c)
  );

  assign w_last = (r_cnt == C_LAST);

  // Next-state decode: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (w_next == ST_DONE);
    end
  end

  // Operand capture, bit-serial add and result/flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + C_ONE;
          // The carry produced by bit WIDTH-2 is the carry into the MSB.
          if (r_cnt == C_PREV) r_cmsb <= w_c;
          if (w_last) begin
            r_cout <= w_c;
            r_ovf  <= r_cmsb ^ w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire
